fitness_evaluator: RTL

Hardware fitness-evaluation engine for the genetic circuit flow. Given a chromosome already loaded into the circuit under evaluation, it steps through up to NUM_SEQ input vectors, lets the circuit settle, and compares its outputs against expected values under a per-sequence valid mask. It accumulates per-lane error sums and hands them back to the HPS through a start/ready/done/ack handshake. It generalises the fixed 16-sequence / 8-sum PIO arrangement into a parametrised, self-sequencing block.

---
 rtl/fitness_pkg.sv | 39 +++
 rtl/lane_error_acc.sv | 24 ++
 rtl/fitness_evaluator.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fitness_pkg.sv
// rtl/fitness_pkg.sv - shared types and arithmetic helpers for the fitness evaluator
package fitness_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    DONE
  } fit_state_t;

  // Widest lane slice / error sum the helpers handle; callers zero-extend into it.
  localparam int MAX_W = 64;

  function automatic int seq_idx_w(input int num_seq);
    return $clog2(num_seq + 1);
  endfunction

  localparam int SEQ_IDX_W = seq_idx_w(16);

  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int               w);
    logic [MAX_W:0] s;
    logic [MAX_W:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = ({{MAX_W{1'b0}}, 1'b1} << w) - 1'b1;
    return (s > lim) ? lim[MAX_W-1:0] : s[MAX_W-1:0];
  endfunction

  function automatic int popcount(input logic [MAX_W-1:0] v, input int w);
    int c;
    c = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w && v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/lane_error_acc.sv
// rtl/lane_error_acc.sv - saturating per-lane mismatch accumulator
module lane_error_acc
  import fitness_pkg::*;
#(
  parameter int LANE_W = 4,
  parameter int ERR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [LANE_W-1:0] diff,
  output logic [ERR_W-1:0]  sum
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum <= '0;
    end else if (enable) begin
      sum <= ERR_W'(sat_add(MAX_W'(sum), MAX_W'(popcount(MAX_W'(diff), LANE_W)), ERR_W));
    end
  end

endmodule

// File: rtl/fitness_evaluator.sv
// rtl/fitness_evaluator.sv - sequences test vectors through the evaluated circuit and sums lane errors
module fitness_evaluator
  import fitness_pkg::*;
#(
  parameter int NUM_SEQ    = 16,
  parameter int IN_W       = 32,
  parameter int OUT_W      = 32,
  parameter int NUM_CH     = 8,
  parameter int ERR_W      = 32,
  parameter int SETTLE_CYC = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [$clog2(NUM_SEQ+1)-1:0] seq_count,
  input  logic [NUM_SEQ*IN_W-1:0]     input_seq,
  input  logic [NUM_SEQ*OUT_W-1:0]    expected,
  input  logic [NUM_SEQ*OUT_W-1:0]    valid_mask,
  output logic [IN_W-1:0]             dut_in,
  input  logic [OUT_W-1:0]            dut_out,
  output logic                        ready,
  output logic                        done,
  input  logic                        done_ack,
  output logic [NUM_CH*ERR_W-1:0]     error_sum
);

  localparam int LANE_W = OUT_W / NUM_CH;
  localparam int SEQ_W  = seq_idx_w(NUM_SEQ);
  localparam int CNT_W  = $clog2(SETTLE_CYC + 1);
  localparam logic [SEQ_W-1:0] NUM_SEQ_V = SEQ_W'(NUM_SEQ);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYC - 1);

  fit_state_t       state;
  logic             start_q;
  logic             start_edge;
  logic [SEQ_W-1:0] n;
  logic [SEQ_W-1:0] idx;
  logic [SEQ_W-1:0] idx_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IN_W-1:0]  nxt_in;
  logic [OUT_W-1:0] cur_exp;
  logic [OUT_W-1:0] cur_mask;
  logic [OUT_W-1:0] diff;
  logic             lane_en;
  logic             lane_clr;

  assign start_edge = start & ~start_q;
  assign lane_en    = (state == SAMPLE);
  assign lane_clr   = (state == IDLE) && start_edge;
  assign idx_nxt    = (state == IDLE) ? '0 : idx + SEQ_W'(1);

  // Loop muxes keep every slice index a constant, so no out-of-range selects exist.
  always_comb begin
    nxt_in   = '0;
    cur_exp  = '0;
    cur_mask = '0;
    for (int i = 0; i < NUM_SEQ; i++) begin
      if (SEQ_W'(i) == idx_nxt) nxt_in = input_seq[i*IN_W +: IN_W];
      if (SEQ_W'(i) == idx) begin
        cur_exp  = expected[i*OUT_W +: OUT_W];
        cur_mask = valid_mask[i*OUT_W +: OUT_W];
      end
    end
  end

  assign diff = (dut_out ^ cur_exp) & cur_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
      dut_in  <= '0;
      n       <= '0;
      idx     <= '0;
      cnt     <= '0;
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          if (start_edge) begin
            ready <= 1'b0;
            idx   <= '0;
            cnt   <= '0;
            n     <= (seq_count > NUM_SEQ_V) ? NUM_SEQ_V : seq_count;
            if (seq_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= APPLY;
              dut_in <= nxt_in;
            end
          end
        end
        APPLY: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SAMPLE: begin
          // idx never passes n-1, so it always addresses a real sequence slot.
          if (idx == n - SEQ_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            idx    <= idx_nxt;
            dut_in <= nxt_in;
            state  <= APPLY;
          end
        end
        DONE: begin
          if (done_ack) begin
            state <= IDLE;
            done  <= 1'b0;
            ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    lane_error_acc #(
      .LANE_W(LANE_W),
      .ERR_W (ERR_W)
    ) u_acc (
      .clk   (clk),
      .reset (reset),
      .clear (lane_clr),
      .enable(lane_en),
      .diff  (diff[c*LANE_W +: LANE_W]),
      .sum   (error_sum[c*ERR_W +: ERR_W])
    );
  end

endmodule
